// File: rtl/adc_spi_cfg_seq.sv
// adc_spi_cfg_seq
// Upstream sequencer for the AD9222 SPI register writer. A host-loaded table of
// {addr[12:0], data[7:0]} entries is issued to the writer in order 0..len-1 on a
// go strobe. Each entry uses the writer's level command / finish / idle handshake.
//
// Optional feature macro: ADC_SPI_CFG_TIMEOUT_EN
//   defined     : a 16-bit wait counter aborts a stuck handshake phase after
//                 TIMEOUT_CYC cycles (err=1, done pulse, back to idle)
//   not defined : the sequencer waits indefinitely and err stays 0
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/waddr/wdata  table write port, ignored while busy
//   cfg_len             number of entries to issue (0..2^DEPTH_W), sampled on go
//   go                  one-clk start pulse, ignored while busy
//   busy, done, err     status: in progress, end-of-sequence pulse, sticky timeout
//   cur_idx             index of the entry currently issued
//   spi_addr/data/cmd   command to the writer (addr/data stable while cmd=1)
//   spi_finish, spi_en  writer finish flag and idle flag
module adc_spi_cfg_seq #(
    parameter int          DEPTH_W     = 3,
    parameter logic [15:0] TIMEOUT_CYC = 16'd40000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [DEPTH_W-1:0] cfg_waddr,
    input  logic [20:0]        cfg_wdata,
    input  logic [DEPTH_W:0]   cfg_len,
    input  logic               go,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DEPTH_W-1:0] cur_idx,
    output logic [12:0]        spi_addr,
    output logic [7:0]         spi_data,
    output logic               spi_cmd,
    input  logic               spi_finish,
    input  logic               spi_en
);

    localparam int             DEPTH   = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] LEN_ONE = (DEPTH_W+1)'(1'b1);

    // S_ZERO gives the one-cycle busy window of a zero-length sequence.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ZERO     = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_ISSUE    = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [20:0]        table_r [DEPTH];
    logic [DEPTH_W:0]   len_r, len_s;
    logic               busy_s, done_s, err_s, cmd_s;
    logic [DEPTH_W-1:0] idx_s;
    logic [12:0]        addr_s;
    logic [7:0]         data_s;
    logic               writer_free_s;
    logic               last_s;
    logic               tmo_s;
    logic [20:0]        entry_s;

    assign writer_free_s = spi_en & ~spi_finish;
    assign last_s        = ({1'b0, cur_idx} == (len_r - LEN_ONE));
    assign entry_s       = table_r[cur_idx];

`ifdef ADC_SPI_CFG_TIMEOUT_EN
    logic [15:0] wait_cnt_r;
    logic        waiting_s;

    assign waiting_s = (state_r == S_WAIT_RDY) || (state_r == S_ISSUE) || (state_r == S_RELEASE);
    // Firing when the count is about to reach TIMEOUT_CYC makes a phase last exactly TIMEOUT_CYC cycles.
    assign tmo_s     = waiting_s && (wait_cnt_r == (TIMEOUT_CYC - 16'd1));

    // Wait counter: restarts on every state change, counts only while waiting on the writer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_s != state_r) || !waiting_s) begin
            wait_cnt_r <= 16'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // Table write port; locked while a sequence runs. Contents are not reset.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            table_r[cfg_waddr] <= cfg_wdata;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        len_s   = len_r;
        busy_s  = busy;
        done_s  = 1'b0;
        err_s   = err;
        idx_s   = cur_idx;
        addr_s  = spi_addr;
        data_s  = spi_data;
        cmd_s   = spi_cmd;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    len_s  = cfg_len;
                    err_s  = 1'b0;
                    idx_s  = '0;
                    busy_s = 1'b1;
                    if (cfg_len == {(DEPTH_W+1){1'b0}}) begin
                        state_s = S_ZERO;
                    end else begin
                        state_s = S_WAIT_RDY;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_ZERO: begin
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = S_IDLE;
            end
            S_WAIT_RDY: begin
                // A stale finish from the previous command also blocks the issue.
                if (writer_free_s) begin
                    addr_s  = entry_s[20:8];
                    data_s  = entry_s[7:0];
                    cmd_s   = 1'b1;
                    state_s = S_ISSUE;
                end else if (tmo_s) begin
                    err_s   = 1'b1;
                    cmd_s   = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT_RDY;
                end
            end
            S_ISSUE: begin
                if (spi_finish) begin
                    cmd_s   = 1'b0;
                    state_s = S_RELEASE;
                end else if (tmo_s) begin
                    err_s   = 1'b1;
                    cmd_s   = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    cmd_s   = 1'b1;
                end
            end
            S_RELEASE: begin
                if (writer_free_s) begin
                    if (last_s) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        idx_s   = cur_idx + DEPTH_W'(1'b1);
                        state_s = S_WAIT_RDY;
                    end
                end else if (tmo_s) begin
                    err_s   = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RELEASE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                cmd_s   = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops spi_cmd immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            len_r    <= {(DEPTH_W+1){1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cur_idx  <= {DEPTH_W{1'b0}};
            spi_addr <= 13'd0;
            spi_data <= 8'd0;
            spi_cmd  <= 1'b0;
        end else begin
            state_r  <= state_s;
            len_r    <= len_s;
            busy     <= busy_s;
            done     <= done_s;
            err      <= err_s;
            cur_idx  <= idx_s;
            spi_addr <= addr_s;
            spi_data <= data_s;
            spi_cmd  <= cmd_s;
        end
    end

endmodule

// File: tb/tb_adc_spi_cfg_seq.sv
// Self-checking bench for adc_spi_cfg_seq: a writer model answers the handshake,
// a behavioural model checks handshake rules, issued entries and busy/done timing.
module tb_adc_spi_cfg_seq;

`ifdef ADC_SPI_CFG_TIMEOUT_EN
    localparam logic [15:0] TB_TMO = 16'd100;
`else
    localparam logic [15:0] TB_TMO = 16'd40000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_waddr = 3'd0;
    logic [20:0] cfg_wdata = 21'd0;
    logic [3:0]  cfg_len = 4'd0;
    logic        go = 1'b0;
    logic        busy, done, err, spi_cmd;
    logic [2:0]  cur_idx;
    logic [12:0] spi_addr;
    logic [7:0]  spi_data;
    logic        spi_finish = 1'b0;
    logic        spi_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    adc_spi_cfg_seq #(.DEPTH_W(3), .TIMEOUT_CYC(TB_TMO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
        .cfg_len(cfg_len), .go(go), .busy(busy), .done(done), .err(err), .cur_idx(cur_idx),
        .spi_addr(spi_addr), .spi_data(spi_data), .spi_cmd(spi_cmd),
        .spi_finish(spi_finish), .spi_en(spi_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- writer model ----------------
    logic [20:0] cap[$];
    int  w_ph = 0;     // 0 idle, 1 writing, 2 finish shown, 3 finish tail, 4 power-up
    int  w_cnt = 0;
    bit  pu_req = 1'b1;
    bit  hold_fin = 1'b0;

    initial begin
        forever begin
            tick;
            if (rst) pu_req = 1'b1;
            case (w_ph)
                0: begin
                    if (pu_req && !rst) begin
                        spi_en = 1'b0; w_cnt = 15; w_ph = 4; pu_req = 1'b0;
                    end else if (spi_cmd) begin
                        cap.push_back({spi_addr, spi_data});
                        spi_en = 1'b0; w_cnt = $urandom_range(1, 6); w_ph = 1;
                    end
                end
                1: begin
                    if (!hold_fin) begin
                        w_cnt--;
                        if (w_cnt == 0) begin spi_finish = 1'b1; w_ph = 2; end
                    end
                end
                2: begin
                    if (!spi_cmd) begin
                        if (pu_req) begin
                            spi_finish = 1'b0; w_cnt = 15; w_ph = 4; pu_req = 1'b0;
                        end else begin
                            spi_en = 1'b1;
                            w_cnt = $urandom_range(0, 2);
                            if (w_cnt == 0) begin spi_finish = 1'b0; w_ph = 0; end
                            else w_ph = 3;
                        end
                    end
                end
                3: begin
                    w_cnt--;
                    if (w_cnt == 0) begin spi_finish = 1'b0; w_ph = 0; end
                end
                default: begin
                    w_cnt--;
                    if (w_cnt == 0) begin spi_en = 1'b1; spi_finish = 1'b1; w_cnt = 2; w_ph = 3; end
                end
            endcase
        end
    end

    // ---------------- behavioural model + compare ----------------
    logic [20:0] m_table [8];
    bit   chk_en = 1'b1;
    bit   m_active = 1'b0, m_zero = 1'b0;
    int   m_len = 0, m_issued = 0;
    bit   exp_busy = 1'b0, exp_done = 1'b0, exp_acc = 1'b0;
    bit   p_cmd = 1'b0, p_en = 1'b0, p_fin = 1'b0;
    logic [20:0] cur_word = 21'd0;

    initial begin
        for (int i = 0; i < 8; i++) m_table[i] = 21'd0;
        forever begin
            @(negedge clk);
            if (rst || !chk_en) begin
                m_active = 1'b0; m_zero = 1'b0;
                exp_busy = 1'b0; exp_done = 1'b0; exp_acc = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("done", 32'(done), 32'(exp_done));
`ifndef ADC_SPI_CFG_TIMEOUT_EN
                chk("err_zero", 32'(err), 32'd0);
`endif
                if (exp_acc) begin
                    chk("idx_start", 32'(cur_idx), 32'd0);
                    chk("err_clear", 32'(err), 32'd0);
                end
                if (!exp_busy) chk("cmd_idle", 32'(spi_cmd), 32'd0);
                if (spi_cmd && !p_cmd) begin
                    chk("cmd_gate", {30'd0, p_en, p_fin}, 32'd2);
                    chk("rise_idx", 32'(cur_idx), 32'(m_issued));
                    if (m_issued < m_len) begin
                        cur_word = m_table[m_issued];
                        chk("entry", 32'({spi_addr, spi_data}), 32'(cur_word));
                    end else begin
                        chk("extra_write", 32'(m_issued), 32'(m_len));
                    end
                    m_issued++;
                end else if (spi_cmd && p_cmd) begin
                    chk("stable", 32'({spi_addr, spi_data}), 32'(cur_word));
                end
                if (p_cmd) chk("cmd_follow", 32'(spi_cmd), 32'(!p_fin));
                // predict the next cycle
                exp_acc = 1'b0; exp_done = 1'b0;
                if (!m_active) begin
                    if (cfg_we) m_table[cfg_waddr] = cfg_wdata;
                    if (go) begin
                        m_active = 1'b1; m_len = int'(cfg_len); m_issued = 0;
                        m_zero = (cfg_len == 4'd0); exp_acc = 1'b1;
                    end
                end else if (m_zero) begin
                    exp_done = 1'b1; m_active = 1'b0;
                end else if (m_issued == m_len && !spi_cmd && spi_en && !spi_finish) begin
                    exp_done = 1'b1; m_active = 1'b0;
                end
                exp_busy = m_active;
            end
            p_cmd = rst ? 1'b0 : spi_cmd;
            p_en = spi_en; p_fin = spi_finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [2:0] a, input logic [20:0] w);
        cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = w;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(input bit noise);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (noise && busy) begin
                go = 1'($urandom_range(0, 1));
                cfg_we = 1'($urandom_range(0, 1));
                cfg_waddr = 3'd0; cfg_wdata = {13'h1ABC, 8'hFF};
            end else begin
                go = 1'b0; cfg_we = 1'b0;
            end
            tick;
            if (done) seen = 1'b1;
        end
        go = 1'b0; cfg_we = 1'b0;
        chk("seq_end", 32'(seen), 32'd1);
    endtask

    task automatic run_seq(input int len, input bit noise, input bit same_we);
        cfg_len = 4'(len); go = 1'b1;
        if (same_we) begin
            cfg_we = 1'b1; cfg_waddr = 3'($urandom_range(0, 7)); cfg_wdata = 21'($urandom);
        end
        tick;
        go = 1'b0; cfg_we = 1'b0;
        wait_done(noise);
        repeat ($urandom_range(0, 3)) tick;
    endtask

    initial begin
        logic [20:0] e0;
        int cnt;
        #900000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [20:0] e0;
        int cnt;
        repeat (4) tick;
        // reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_idx", 32'(cur_idx), 32'd0);
        chk("rst_addr", 32'(spi_addr), 32'd0);
        chk("rst_data", 32'(spi_data), 32'd0);
        chk("rst_cmd", 32'(spi_cmd), 32'd0);
        rst = 1'b0;

        // T1 + T3: two entries, go 5 clk after reset release, inside the power-up write
        tick;
        load(3'd0, {13'h014, 8'h01});
        load(3'd1, {13'h00D, 8'h04});
        tick;
        cap.delete();
        cfg_len = 4'd2; go = 1'b1;
        tick;
        go = 1'b0;
        cnt = 0;
        while (!spi_en && cnt < 100) begin
            chk("t3_cmd_held", 32'(spi_cmd), 32'd0);
            tick; cnt++;
        end
        chk("t3_pu_ends", 32'(spi_en), 32'd1);
        wait_done(1'b0);
        chk("t1_nwrites", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("t1_w0", 32'(cap[0]), 32'h001401);
            chk("t1_w1", 32'(cap[1]), 32'h000D04);
        end
        chk("t1_err", 32'(err), 32'd0);
        tick;

        // T2: zero-length sequence
        cfg_len = 4'd0; go = 1'b1;
        tick;
        go = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_nodone", 32'(done), 32'd0);
        tick;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_cmd", 32'(spi_cmd), 32'd0);
        tick;
        chk("t2_done_1clk", 32'(done), 32'd0);

        // fill the table
        e0 = 21'h0ABC5A;
        load(3'd0, e0);
        for (int i = 1; i < 8; i++) load(3'(i), 21'($urandom));

        // T4: go and cfg_we to index 0 while busy are ignored
        run_seq(8, 1'b1, 1'b0);
        run_seq(3, 1'b1, 1'b0);
        cap.delete();
        run_seq(1, 1'b0, 1'b0);
        chk("t4_nwrites", 32'(cap.size()), 32'd1);
        if (cap.size() == 1) chk("t4_entry0", 32'(cap[0]), 32'(e0));

        // randomized sequences
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 2; j++) load(3'($urandom_range(0, 7)), 21'($urandom));
            end
            run_seq($urandom_range(0, 8), (k % 3) == 0, (k % 4) == 1);
        end

`ifdef ADC_SPI_CFG_TIMEOUT_EN
        // T5: writer never finishes -> timeout after 100 clk in ISSUE
        chk_en = 1'b0; hold_fin = 1'b1;
        tick;
        cfg_len = 4'd1; go = 1'b1;
        tick;
        go = 1'b0;
        cnt = 0;
        while (!spi_cmd && cnt < 200) begin tick; cnt++; end
        chk("t5_issue", 32'(spi_cmd), 32'd1);
        cnt = 0;
        while (spi_cmd && cnt < 500) begin tick; cnt++; end
        chk("t5_cycles", 32'(cnt), 32'd100);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        hold_fin = 1'b0;
        cnt = 0;
        while (!(w_ph == 0 && spi_en && !spi_finish) && cnt < 200) begin tick; cnt++; end
        cfg_len = 4'd0; go = 1'b1;
        tick;
        go = 1'b0;
        chk("t5_err_clr", 32'(err), 32'd0);
        tick; tick;
        chk_en = 1'b1;
        tick;
`endif

        // T6: reset while an entry is in ISSUE, then a full sequence
        cfg_len = 4'd3; go = 1'b1;
        tick;
        go = 1'b0;
        cnt = 0;
        while (!spi_cmd && cnt < 200) begin tick; cnt++; end
        chk("t6_issue", 32'(spi_cmd), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_cmd", 32'(spi_cmd), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_idx", 32'(cur_idx), 32'd0);
        chk("t6_addr", 32'({spi_addr, spi_data}), 32'd0);
        chk("t6_flags", {30'd0, done, err}, 32'd0);
        repeat (3) tick;
        rst = 1'b0;
        tick;
        cap.delete();
        run_seq(8, 1'b0, 1'b0);
        chk("t6_nwrites", 32'(cap.size()), 32'd8);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
